// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: operand FIFO + restart sequencer for the 16-bit sqrt core.
// Ports: in_* operand stream, out_* result stream, core_* core link, busy.
// Optional: define SQRT_CYCLE_COUNT_EN to add out_cycles[10:0].
module sqrt_dispatch #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W/2-1:0] out_root,
  output logic [DATA_W-1:0]   out_value,
  output logic                out_err,
`ifdef SQRT_CYCLE_COUNT_EN
  output logic [10:0]         out_cycles,
`endif
  output logic                core_rst_n,
  output logic [DATA_W-1:0]   core_valor,
  input  logic                core_ready,
  input  logic [DATA_W/2-1:0] core_root,
  output logic                busy
);

  localparam int RW = DATA_W / 2;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty;
  logic              push, pop;

  logic [10:0]       cnt, cnt_inc;
  logic [RW-1:0]     res_root;
  logic              res_err;
`ifdef SQRT_CYCLE_COUNT_EN
  logic [10:0]       res_cyc;
`endif
  logic              slot_free;
  logic              run_ok, run_to;
  logic              load_out;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

  // Count value after this RUN cycle; saturates
  assign cnt_inc   = (cnt == 11'h7ff) ? cnt : cnt + 11'd1;
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    run_ok    = 1'b0;
    run_to    = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = RUN;
      RUN: begin
        if (core_ready) begin
          run_ok    = 1'b1;
          state_nxt = DONE;
        end else if (cnt_inc == 11'(TIMEOUT_CYC)) begin
          run_to    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (slot_free) begin
          load_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_rst_n <= 1'b0;
      core_valor <= '0;
      cnt        <= '0;
      res_root   <= '0;
      res_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_root   <= '0;
      out_value  <= '0;
      out_err    <= 1'b0;
`ifdef SQRT_CYCLE_COUNT_EN
      res_cyc    <= '0;
      out_cycles <= '0;
`endif
    end else begin
      state      <= state_nxt;
      // Low only for the pop cycle: one-clock restart
      core_rst_n <= !pop;
      if (pop) begin
        core_valor <= mem[rd_ptr];
        cnt        <= '0;
      end else if (state == RUN) begin
        cnt <= cnt_inc;
      end
      if (run_ok) begin
        res_root <= core_root;
        res_err  <= 1'b0;
      end else if (run_to) begin
        res_root <= '1;
        res_err  <= 1'b1;
      end
`ifdef SQRT_CYCLE_COUNT_EN
      if (run_ok || run_to) res_cyc <= cnt_inc;
`endif
      if (load_out) begin
        out_valid  <= 1'b1;
        out_root   <= res_root;
        out_value  <= core_valor;
        out_err    <= res_err;
`ifdef SQRT_CYCLE_COUNT_EN
        out_cycles <= res_cyc;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sqrt_dispatch.md
# sqrt_dispatch

Operand dispatcher that sits directly upstream of the 16-bit square-root core (`Top`). It accepts operands on a valid/ready stream and buffers them in a small FIFO. For each operand it restarts the core with a one-cycle `core_rst_n` pulse, waits for `core_ready`, then returns root, operand and status on a valid/ready result stream. It replaces the per-operation reset sequencing that benches and software otherwise perform by hand.

## Interface
- `DATA_W`, 16, operand width; root width is `DATA_W/2`.
- `FIFO_DEPTH`, 2, operand FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT_CYC`, 1023, maximum RUN cycles before the operation is aborted; range 1..2047.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: FIFO not full.
- `in_data` in `DATA_W`: operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accepted.
- `out_root` out `DATA_W/2`: root.
- `out_value` out `DATA_W`: operand echo.
- `out_err` out 1: timeout flag for this result.
- `core_rst_n` out 1: registered restart to core `rst_n`.
- `core_valor` out `DATA_W`: to core `valor_i`, stable for the whole operation.
- `core_ready` in 1: from core `ready_o`.
- `core_root` in `DATA_W/2`: from core `root_o`.
- `busy` out 1: FSM not IDLE, or FIFO not empty.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`; pop only in IDLE.
  - No bypass: an operand pushed into an empty FIFO is popped no earlier than the next edge.
  - `in_ready = !full` is combinational from the occupancy count, so a push is never accepted when full, even if a pop happens in the same cycle.
- **FSM states: IDLE, LAUNCH, RUN, DONE**
  - IDLE: if the FIFO is not empty, pop into `core_valor`, drive `core_rst_n <= 0`, clear the cycle counter, go to LAUNCH.
  - LAUNCH: `core_rst_n <= 1`, go to RUN. `core_rst_n` is therefore low for exactly one clock.
  - RUN: the counter increments every cycle.
    - If `core_ready == 1`, latch `core_root`, set `err = 0`, go to DONE.
    - Otherwise, if the counter equals `TIMEOUT_CYC`, latch root = all ones, set `err = 1`, go to DONE.
  - DONE: when the output slot is free (`!out_valid`, or `out_valid && out_ready` in this cycle), load `out_root`, `out_value`, `out_err`, set `out_valid`, go to IDLE. Otherwise hold.
- **Core contract:** the core clears `ready_o` asynchronously while its `rst_n` is low. A stale `ready` from the previous operation is therefore never visible in RUN.
- **Output register:** `out_valid` clears on `out_valid && out_ready` unless DONE reloads it in the same cycle. Results leave in operand order.
- **Counter:** 11 bits, saturating at 2047.

## Timing
- **Reset values:**
  - `in_ready = 1`, `out_valid = 0`, `out_root = 0`, `out_value = 0`, `out_err = 0`.
  - `core_rst_n = 0`, `core_valor = 0`, `busy = 0`, state IDLE, FIFO empty.
  - `core_rst_n` rises at the first clock edge after `rst_n` deasserts.
- **Latency:** operand pushed at edge E into an empty FIFO with the FSM in IDLE:
  - pop and `core_rst_n` falls at E+1;
  - `core_rst_n` rises and RUN is entered at E+2;
  - `core_ready` sampled at edge E+2+N gives `out_valid` at E+3+N.
- **Back-to-back:** the next pop occurs in the IDLE cycle right after DONE. Core restarts are separated by at least 3 cycles.
- **Reset mid-operation:** everything above is cleared asynchronously and the in-flight operand and queued operands are discarded. `core_rst_n` goes low immediately.
- **Simultaneous push and pop** with the FIFO at count 1: the count stays 1.

## Configuration
- `SQRT_CYCLE_COUNT_EN` defined: adds output `out_cycles[10:0]` (reset value 0).
  - It carries the RUN cycle count of the result, latched with `out_root`.
  - It equals N for the sample at E+2+N, or `TIMEOUT_CYC` on error.
- Undefined: the port and its register are absent. The internal counter remains, since timeout uses it.

## Test plan
- **Reset:** assert `rst_n` mid-RUN → all outputs return to their reset values within the same cycle, queued operands are lost, and the next result corresponds to the first operand pushed after reset.
- **Single operand:** push 65535 → `core_rst_n` low for exactly 1 cycle, `core_valor = 65535`; result `out_root = 255`, `out_value = 65535`, `out_err = 0`.
- **Back-pressure:** hold `out_ready = 0`, push 0, 1, 50000, 40000 →
  - `in_ready` drops when the FIFO holds 2 entries;
  - after releasing `out_ready`, results arrive in order as 0, 1, 223, 200.
- **Timeout:** the core model never asserts ready → after 1023 RUN cycles, `out_valid = 1`, `out_err = 1`, `out_root = 8'hFF`; the next operand then completes normally.
- **Cycle count:** with `SQRT_CYCLE_COUNT_EN` defined and the core model asserting ready 17 cycles into RUN → `out_cycles = 17`, and `out_valid` rises 20 edges after the push edge.
